// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared axis state encoding and direction constant
package step_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } axis_state_e;

   localparam logic DIR_POS = 1'b1;

endpackage

// File: rtl/axis_step_gen.sv
// rtl/axis_step_gen.sv - one stepper axis: request edge detect, pending slot,
// STEP/DIR timing FSM and commanded position counter
module axis_step_gen
   import step_pkg::*;
#(
   parameter int W_POS     = 16,
   parameter int CNT_W     = 8,
   parameter int DIR_SETUP = 2,
   parameter int STEP_HI   = 4,
   parameter int STEP_LO   = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [W_POS-1:0] preset_i,
   input  logic             acc_i,
   input  logic             dec_i,
   output logic             step_o,
   output logic             dir_o,
   output logic [W_POS-1:0] pos_o,
   output logic             active_o,
   output logic             drop_o
);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP - 1);
   localparam logic [CNT_W-1:0] HI_LD    = CNT_W'(STEP_HI - 1);
   localparam logic [CNT_W-1:0] LO_LD    = CNT_W'(STEP_LO - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [W_POS-1:0] POS_ONE  = W_POS'(1);

   axis_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [W_POS-1:0] pos_q, pos_d;
   logic             pend_v_q, pend_v_d;
   logic             pend_dir_q, pend_dir_d;
   logic             acc_q, dec_q;

   logic acc_e, dec_e, req, req_dir, cnt_zero, consume, launch, launch_dir;
   logic [W_POS-1:0] pos_up, pos_dn;

   assign acc_e    = acc_i & ~acc_q;
   assign dec_e    = dec_i & ~dec_q;
   assign req      = acc_e ^ dec_e;
   assign req_dir  = acc_e ? DIR_POS : ~DIR_POS;
   assign cnt_zero = (cnt_q == '0);
   assign pos_up   = pos_q + POS_ONE;
   assign pos_dn   = pos_q - POS_ONE;

   // The pending slot is drained from IDLE or at the last LOW cycle, which frees it for a new request that same cycle.
   assign consume    = pend_v_q & ((state_q == ST_IDLE) | ((state_q == ST_LOW) & cnt_zero));
   assign launch     = consume | (req & ~pend_v_q & (state_q == ST_IDLE));
   assign launch_dir = consume ? pend_dir_q : req_dir;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      pos_d      = pos_q;
      pend_v_d   = pend_v_q & ~consume;
      pend_dir_d = pend_dir_q;
      drop_o     = acc_e & dec_e;

      if (req && !(state_q == ST_IDLE && !pend_v_q)) begin
         if (pend_v_q && !consume) begin
            drop_o = 1'b1;
         end else begin
            pend_v_d   = 1'b1;
            pend_dir_d = req_dir;
         end
      end

      case (state_q)
         ST_SETUP: begin
            if (cnt_zero) begin
               state_d = ST_HIGH;
               cnt_d   = HI_LD;
               pos_d   = (dir_q == DIR_POS) ? pos_up : pos_dn;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (cnt_zero) begin
               state_d = ST_LOW;
               cnt_d   = LO_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_LOW: begin
            if (cnt_zero) state_d = ST_IDLE;
            else          cnt_d   = cnt_q - CNT_ONE;
         end
         default: ;
      endcase

      if (launch) begin
         if (launch_dir == dir_q) begin
            state_d = ST_HIGH;
            cnt_d   = HI_LD;
            pos_d   = (launch_dir == DIR_POS) ? pos_up : pos_dn;
         end else begin
            dir_d   = launch_dir;
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
         end
      end

      if (load_i) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         pos_d    = preset_i;
         pend_v_d = 1'b0;
         drop_o   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         pos_q      <= '0;
         pend_v_q   <= 1'b0;
         pend_dir_q <= 1'b0;
         acc_q      <= 1'b0;
         dec_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         pos_q      <= pos_d;
         pend_v_q   <= pend_v_d;
         pend_dir_q <= pend_dir_d;
         acc_q      <= acc_i;
         dec_q      <= dec_i;
      end
   end

   assign step_o   = (state_q == ST_HIGH);
   assign dir_o    = dir_q;
   assign pos_o    = pos_q;
   assign active_o = (state_q != ST_IDLE) | pend_v_q;

endmodule

// File: rtl/step_dir_driver.sv
// rtl/step_dir_driver.sv - two-axis STEP/DIR driver fed by interpolator step pulses
module step_dir_driver
   import step_pkg::*;
#(
   parameter int W_POS     = 16,
   parameter int CNT_W     = 8,
   parameter int DIR_SETUP = 2,
   parameter int STEP_HI   = 4,
   parameter int STEP_LO   = 4
) (
   input  logic                    pulse_clk,
   input  logic                    sys_rst,
   input  logic                    load_pos,
   input  logic signed [W_POS-1:0] Xs,
   input  logic signed [W_POS-1:0] Ys,
   input  logic                    X_acc,
   input  logic                    X_dec,
   input  logic                    Y_acc,
   input  logic                    Y_dec,
   input  logic                    draw_overH,
   output logic                    X_step,
   output logic                    X_dir,
   output logic                    Y_step,
   output logic                    Y_dir,
   output logic signed [W_POS-1:0] X_pos,
   output logic signed [W_POS-1:0] Y_pos,
   output logic                    busy,
   output logic                    overrun,
   output logic                    done
);

   logic x_active, y_active, x_drop, y_drop;
   logic draw_q, armed_q, armed_d, done_q, done_d, overrun_q, overrun_d, busy_q, busy_d;

   axis_step_gen #(
      .W_POS(W_POS), .CNT_W(CNT_W), .DIR_SETUP(DIR_SETUP), .STEP_HI(STEP_HI), .STEP_LO(STEP_LO)
   ) u_x (
      .clk_i(pulse_clk), .rst_i(sys_rst), .load_i(load_pos), .preset_i(Xs),
      .acc_i(X_acc), .dec_i(X_dec), .step_o(X_step), .dir_o(X_dir), .pos_o(X_pos),
      .active_o(x_active), .drop_o(x_drop)
   );

   axis_step_gen #(
      .W_POS(W_POS), .CNT_W(CNT_W), .DIR_SETUP(DIR_SETUP), .STEP_HI(STEP_HI), .STEP_LO(STEP_LO)
   ) u_y (
      .clk_i(pulse_clk), .rst_i(sys_rst), .load_i(load_pos), .preset_i(Ys),
      .acc_i(Y_acc), .dec_i(Y_dec), .step_o(Y_step), .dir_o(Y_dir), .pos_o(Y_pos),
      .active_o(y_active), .drop_o(y_drop)
   );

   // Arming is cleared by load_pos too, otherwise an idle machine would re-assert done right after a preset.
   always_comb begin
      armed_d   = armed_q | (draw_overH & ~draw_q);
      done_d    = done_q | (armed_q & ~x_active & ~y_active);
      overrun_d = overrun_q | x_drop | y_drop;
      busy_d    = x_active | y_active;
      if (load_pos) begin
         armed_d   = 1'b0;
         done_d    = 1'b0;
         overrun_d = 1'b0;
         busy_d    = 1'b0;
      end
   end

   always_ff @(posedge pulse_clk) begin
      if (sys_rst) begin
         draw_q    <= 1'b0;
         armed_q   <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         draw_q    <= draw_overH;
         armed_q   <= armed_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         busy_q    <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign overrun = overrun_q;
   assign done    = done_q;

endmodule

// File: tb/tb_step_dir_driver.sv
// tb/tb_step_dir_driver.sv - scoreboard bench for step_dir_driver
module tb_step_dir_driver;

   localparam int DS = 2;
   localparam int HI = 4;
   localparam int LO = 4;

   logic pulse_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic load_pos = 1'b0;
   logic signed [15:0] Xs = '0;
   logic signed [15:0] Ys = '0;
   logic X_acc = 1'b0, X_dec = 1'b0, Y_acc = 1'b0, Y_dec = 1'b0, draw_overH = 1'b0;
   logic X_step, X_dir, Y_step, Y_dir, busy, overrun, done;
   logic signed [15:0] X_pos, Y_pos;

   step_dir_driver #(.W_POS(16), .CNT_W(8), .DIR_SETUP(DS), .STEP_HI(HI), .STEP_LO(LO)) dut (
      .pulse_clk(pulse_clk), .sys_rst(sys_rst), .load_pos(load_pos), .Xs(Xs), .Ys(Ys),
      .X_acc(X_acc), .X_dec(X_dec), .Y_acc(Y_acc), .Y_dec(Y_dec), .draw_overH(draw_overH),
      .X_step(X_step), .X_dir(X_dir), .Y_step(Y_step), .Y_dir(Y_dir),
      .X_pos(X_pos), .Y_pos(Y_pos), .busy(busy), .overrun(overrun), .done(done)
   );

   always #5 pulse_clk = ~pulse_clk;

   int cyc = 0;
   always @(posedge pulse_clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int                 rise;
      logic               dir;
      logic signed [15:0] pos;
   } exp_t;

   exp_t qx[$];
   exp_t qy[$];

   // Reference model: each accepted step is a scheduled interval [start, end] on its axis.
   int                 m_start[2] = '{-100, -100};
   int                 m_end[2]   = '{-100, -100};
   logic               m_dir[2]   = '{1'b0, 1'b0};
   logic signed [15:0] m_pos[2]   = '{16'sd0, 16'sd0};
   bit                 m_ov = 1'b0;
   bit                 m_armed = 1'b0;
   int                 m_draw = -100;
   int                 last_load = -100;
   bit p_ax = 0, p_dx = 0, p_ay = 0, p_dy = 0, p_dr = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_req(input int a, input bit acc_e, input bit dec_e, input int n);
      int start;
      int s;
      exp_t e;
      if (acc_e && dec_e) begin
         m_ov = 1'b1;
      end else if (acc_e || dec_e) begin
         if (m_start[a] > n) begin
            m_ov = 1'b1;
         end else begin
            if (n > m_end[a])       start = n;
            else if (n == m_end[a]) start = n + 1;
            else                    start = m_end[a];
            s = (acc_e != m_dir[a]) ? DS : 0;
            m_dir[a] = acc_e;
            m_pos[a] = acc_e ? m_pos[a] + 16'sd1 : m_pos[a] - 16'sd1;
            e.rise = start + 1 + s;
            e.dir  = acc_e;
            e.pos  = m_pos[a];
            if (a == 0) qx.push_back(e);
            else        qy.push_back(e);
            m_start[a] = start;
            m_end[a]   = start + s + HI + LO;
         end
      end
   endtask

   task automatic step_cyc(input bit ax, input bit dx, input bit ay, input bit dy, input bit ld, input bit dr);
      int n;
      n = cyc;
      X_acc = ax; X_dec = dx; Y_acc = ay; Y_dec = dy; load_pos = ld; draw_overH = dr;
      if (ld) begin
         m_pos[0] = Xs; m_pos[1] = Ys;
         m_start = '{-100, -100};
         m_end   = '{-100, -100};
         m_ov = 1'b0; m_armed = 1'b0; last_load = n;
         while (qx.size() > 0 && qx[qx.size()-1].rise > n) void'(qx.pop_back());
         while (qy.size() > 0 && qy[qy.size()-1].rise > n) void'(qy.pop_back());
      end else begin
         model_req(0, ax & ~p_ax, dx & ~p_dx, n);
         model_req(1, ay & ~p_ay, dy & ~p_dy, n);
         if (dr && !p_dr && !m_armed) begin
            m_armed = 1'b1;
            m_draw  = n;
         end
      end
      p_ax = ax; p_dx = dx; p_ay = ay; p_dy = dy; p_dr = dr;
      @(posedge pulse_clk);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) step_cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_load(input int x, input int y);
      Xs = 16'(x); Ys = 16'(y);
      step_cyc(0, 0, 0, 0, 1, 0);
   endtask

   task automatic check_done(input string nm);
      int e;
      e = m_draw + 1;
      if (m_end[0] + 1 > e) e = m_end[0] + 1;
      if (m_end[1] + 1 > e) e = m_end[1] + 1;
      e = e + 1;
      if (e - cyc > 1000 || e - 1 < cyc) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_window: expected done at cycle %0d, now %0d", nm, e, cyc);
      end else begin
         while (cyc < e - 1) step_cyc(0, 0, 0, 0, 0, 0);
         chk({nm, "_before"}, int'(done), 0);
         step_cyc(0, 0, 0, 0, 0, 0);
         chk({nm, "_at"}, int'(done), 1);
      end
   endtask

   // Monitor: every STEP rising edge pops one expected step of that axis.
   logic xs_p = 1'b0, ys_p = 1'b0;
   int xr = -100, yr = -100, x_gap = 0;

   task automatic on_rise(input string pfx, input int a, input logic dir, input logic signed [15:0] pos);
      exp_t e;
      if ((a == 0 && qx.size() == 0) || (a == 1 && qy.size() == 0)) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_unexpected_step: got a STEP edge, required none (cycle %0d)", pfx, cyc);
      end else begin
         if (a == 0) e = qx.pop_front();
         else        e = qy.pop_front();
         chk({pfx, "_rise_cycle"}, cyc, e.rise);
         chk({pfx, "_dir"}, int'(dir), int'(e.dir));
         chk({pfx, "_pos"}, int'(pos), int'(e.pos));
      end
   endtask

   always @(negedge pulse_clk) begin
      if (!sys_rst) begin
         if (X_step && !xs_p) begin
            on_rise("x", 0, X_dir, X_pos);
            x_gap = cyc - xr;
            xr = cyc;
         end
         if (!X_step && xs_p && last_load < xr) chk("x_high_width", cyc - xr, HI);
         if (Y_step && !ys_p) begin
            on_rise("y", 1, Y_dir, Y_pos);
            yr = cyc;
         end
         if (!Y_step && ys_p && last_load < yr) chk("y_high_width", cyc - yr, HI);
      end
      xs_p = X_step;
      ys_p = Y_step;
   end

   initial begin
      int n;
      int r;
      bit ax, dx, ay, dy;
      logic signed [15:0] p0;

      repeat (3) @(posedge pulse_clk);
      #1;
      chk("rst_flags", int'({X_step, X_dir, Y_step, Y_dir, busy, overrun, done}), 0);
      chk("rst_x_pos", int'(X_pos), 0);
      chk("rst_y_pos", int'(Y_pos), 0);
      sys_rst = 1'b0;

      // Preset then one X_acc with a direction change
      do_load(5, -3);
      chk("t1_load_x", int'(X_pos), 5);
      chk("t1_load_y", int'(Y_pos), -3);
      step_cyc(1, 0, 0, 0, 0, 0);
      chk("t1_dir_set", int'(X_dir), 1);
      chk("t1_step_setup", int'(X_step), 0);
      idle(1);
      chk("t1_busy", int'(busy), 1);
      idle(14);
      chk("t1_x_pos", int'(X_pos), 6);
      chk("t1_y_pos", int'(Y_pos), -3);
      chk("t1_busy_idle", int'(busy), 0);

      // Three X_dec pulses two cycles apart: emit, pend, drop
      do_load(0, 0);
      step_cyc(0, 1, 0, 0, 0, 0); idle(1);
      step_cyc(0, 1, 0, 0, 0, 0); idle(1);
      step_cyc(0, 1, 0, 0, 0, 0); idle(25);
      chk("t2_overrun", int'(overrun), 1);
      chk("t2_x_pos", int'(X_pos), -2);

      // X_acc then X_dec: second step needs a fresh DIR setup
      do_load(0, 0);
      chk("t3_overrun_clr", int'(overrun), 0);
      step_cyc(1, 0, 0, 0, 0, 0); idle(1);
      step_cyc(0, 1, 0, 0, 0, 0);
      idle(8);
      chk("t3_dir_in_setup", int'(X_dir), 0);
      chk("t3_step_in_setup", int'(X_step), 0);
      idle(20);
      chk("t3_rise_gap", x_gap, HI + LO + DS);
      chk("t3_x_pos", int'(X_pos), int'(m_pos[0]));

      // Simultaneous acc and dec edges are both dropped
      p0 = X_pos;
      step_cyc(1, 1, 0, 0, 0, 0); idle(15);
      chk("t4_overrun", int'(overrun), 1);
      chk("t4_x_pos", int'(X_pos), int'(p0));

      // done waits for the last LOW, then load_pos clears it
      do_load(7, 9);
      step_cyc(0, 0, 1, 0, 0, 0);
      step_cyc(0, 0, 0, 0, 0, 1);
      check_done("t5_done");
      idle(5);
      chk("t5_done_sticky", int'(done), 1);
      do_load(0, 0);
      chk("t5_done_clr", int'(done), 0);

      // Position wrap, then load_pos during HIGH
      do_load(32767, 0);
      step_cyc(1, 0, 0, 0, 0, 0); idle(12);
      chk("t6_wrap", int'(X_pos), -32768);
      step_cyc(1, 0, 0, 0, 0, 0);
      idle(1);
      chk("t6_mid_high", int'(X_step), 1);
      do_load(100, 0);
      chk("t6_abort_step", int'(X_step), 0);
      chk("t6_abort_pos", int'(X_pos), 100);
      idle(12);

      // Randomized traffic with held levels, collisions and overruns
      do_load(0, 0);
      for (int i = 0; i < 3000; i++) begin
         r  = $urandom_range(0, 99);
         ax = (r < 6) || (r == 12) || (r >= 92 && p_ax);
         dx = (r >= 6 && r < 13) || (r >= 92 && p_dx);
         r  = $urandom_range(0, 99);
         ay = (r < 5) || (r == 12) || (r >= 94 && p_ay);
         dy = (r >= 5 && r < 13) || (r >= 94 && p_dy);
         step_cyc(ax, dx, ay, dy, 0, 0);
      end
      idle(40);
      chk("rnd_x_pos", int'(X_pos), int'(m_pos[0]));
      chk("rnd_y_pos", int'(Y_pos), int'(m_pos[1]));
      chk("rnd_overrun", int'(overrun), int'(m_ov));
      chk("rnd_busy", int'(busy), 0);
      step_cyc(0, 0, 0, 0, 0, 1);
      check_done("rnd_done");
      idle(3);
      chk("end_qx_empty", qx.size(), 0);
      chk("end_qy_empty", qy.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/step_dir_driver.md
Name: step_dir_driver

Overview:
- Receiving end of the interpolator step-pulse interface: consumes the one-cycle X_acc/X_dec/Y_acc/Y_dec pulses and the draw_overH flag.
- Converts them into timed STEP/DIR waveforms for two stepper-driver axes, with direction-setup and minimum high/low widths.
- Tracks the signed commanded position of each axis and flags lost pulses.
- Sits between the interpolator and the off-chip motor drivers, in the same pulse_clk domain.

Parameters:
- W_POS, 16, width of the signed position registers and of Xs/Ys.
- CNT_W, 8, width of the timing counters.
- DIR_SETUP, 2, cycles DIR must be stable before a STEP rising edge (1..2^CNT_W-1).
- STEP_HI, 4, STEP high width in cycles (1..2^CNT_W-1).
- STEP_LO, 4, minimum STEP low width in cycles before the next rising edge (1..2^CNT_W-1).

Ports:
- pulse_clk  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- load_pos  in  1  one-cycle strobe: preset positions from Xs/Ys and abort all activity.
- Xs  in  W_POS  signed X preset.
- Ys  in  W_POS  signed Y preset.
- X_acc, X_dec, Y_acc, Y_dec  in  1 each  step requests from the interpolator (+1/-1 per axis).
- draw_overH  in  1  interpolation-complete flag.
- X_step, X_dir, Y_step, Y_dir  out  1 each  driver outputs; dir=1 means positive.
- X_pos, Y_pos  out  W_POS  signed position counted at each emitted STEP.
- busy  out  1  either axis active or holding a pending request.
- overrun  out  1  sticky: a request was dropped.
- done  out  1  draw complete and all steps emitted.

Behaviour:
- Clock and reset: one clock, pulse_clk. Reset sys_rst is synchronous and active-high.
- Reset values: all outputs 0, X_pos=Y_pos=0, edge registers 0, both axis FSMs IDLE, pending empty.
- Request detection: each input is registered. A request is a rising edge, i.e. high now and low last cycle, so a held level counts once.
  - acc and dec edges on the same axis in the same cycle: both dropped, overrun set.
- Axis FSM (per axis, identical): IDLE, SETUP, HIGH, LOW.
  - IDLE + request, dir unchanged: go to HIGH next cycle. STEP=1 and pos±1 take effect in the same registered cycle.
  - IDLE + request, dir changed: DIR updated next cycle, enter SETUP for DIR_SETUP cycles, then HIGH.
  - HIGH lasts STEP_HI cycles with STEP=1, then LOW.
  - LOW lasts STEP_LO cycles with STEP=0. At its end: if pending is valid, consume it as from IDLE (same-dir goes directly to HIGH, else SETUP). Otherwise go to IDLE.
- Latency: request input high in cycle n with the axis IDLE and dir unchanged gives STEP high in cycles n+1..n+STEP_HI, pos updated at n+1.
- Pending buffer: one entry per axis (direction bit plus valid).
  - A request arriving while the axis is not IDLE fills pending.
  - A request arriving while pending is already valid is dropped and sets overrun.
  - A request arriving in the same cycle as the LOW exit fills pending normally (consumed next exit).
- Position: X_pos/Y_pos change only at STEP rising edges. Two's-complement wrap at ±2^(W_POS-1), no saturation.
- load_pos: takes priority over everything except sys_rst. In the next cycle:
  - pos = Xs/Ys;
  - FSMs go to IDLE, pending is cleared, STEP=0;
  - DIR keeps its value;
  - overrun and done are cleared;
  - request edges in the same cycle are ignored.
- done:
  - draw_overH rising edge sets an internal armed flag.
  - done=1 when armed, both axes IDLE and no pending valid. It stays high until load_pos or reset.
  - draw_overH during activity delays done until the last LOW completes.
- busy: OR of (axis state != IDLE) and pending valid, registered.

Decomposition:
- Shared package step_pkg holds the axis state encoding (IDLE/SETUP/HIGH/LOW) and the DIR_POS=1 constant.
- One sub-module, axis_step_gen, is instantiated twice. It contains the edge detect, pending entry, FSM, timing counter and position register.
- The top level handles load_pos fan-out, overrun OR, busy and done.

Test Plan:
- Reset, then load_pos with Xs=5, Ys=-3; one X_acc pulse -> X_dir rises, X_step high 2 cycles later for 4 cycles, X_pos=6, Y_pos=-3.
- Three X_dec pulses 2 cycles apart (defaults) -> first emitted, second pending, third dropped; overrun=1, X_pos=-2 after two STEPs from 0.
- X_acc then X_dec with the axis idle -> the second STEP is preceded by a 2-cycle SETUP with X_dir=0; the rising-edge gap from HIGH start is ≥ STEP_HI+STEP_LO+DIR_SETUP = 10 cycles.
- X_acc and X_dec high in the same cycle -> no STEP, overrun=1, X_pos unchanged.
- Y_acc pulse, then draw_overH one cycle later -> done stays 0 until Y LOW ends, then rises; load_pos clears it.
- X_pos=32767 plus one X_acc -> X_pos=-32768; load_pos mid-HIGH -> X_step=0 next cycle, X_pos=Xs.
